// File: rtl/uart_value_formatter.sv
// uart_value_formatter: formats "<tag>=<decimal value>" into a byte string and
// hands it to a string transmitter via a tx_req/tx_busy/tx_done handshake.
//
// Ports:
//   sys_clk, sys_rst_n        clock, asynchronous active-low reset
//   value_in[31:0], tag_in    value and ASCII label, sampled when fmt_req is accepted
//   fmt_req                   start request (honoured only when idle)
//   fmt_busy, fmt_done        formatter busy level / completion pulse
//   tx_string[1023:0]         message bytes, byte k at [8k+7:8k], byte 0 sent first
//   tx_length[7:0]            number of valid message bytes (3..12)
//   tx_req                    one-cycle send request to the transmitter
//   tx_busy, tx_done          transmitter busy level / completion pulse
module uart_value_formatter (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic [31:0]   value_in,
   input  logic [7:0]    tag_in,
   input  logic          fmt_req,
   output logic          fmt_busy,
   output logic          fmt_done,
   output logic [1023:0] tx_string,
   output logic [7:0]    tx_length,
   output logic          tx_req,
   input  logic          tx_busy,
   input  logic          tx_done
);

   localparam int unsigned VAL_W = 32;
   localparam int unsigned STR_W = 1024;
   localparam int unsigned LEN_W = 8;
   localparam int unsigned IDX_W = 4;
   localparam int unsigned DIG_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CONV,
      ST_SEND,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [VAL_W-1:0]   rem_q, rem_d;
   logic [IDX_W-1:0]   pow_idx_q, pow_idx_d;
   logic [DIG_W-1:0]   digit_q, digit_d;
   logic               started_q, started_d;
   logic [STR_W-1:0]   tx_string_q, tx_string_d;
   logic [LEN_W-1:0]   tx_length_q, tx_length_d;
   logic               tx_req_q, tx_req_d;
   logic               fmt_busy_q, fmt_busy_d;
   logic               fmt_done_q, fmt_done_d;
   logic [VAL_W-1:0]   pow_val;

   // 32-bit decimal place weights; 10^9 is the largest that fits
   function automatic logic [VAL_W-1:0] pow10(input logic [IDX_W-1:0] idx);
      case (idx)
         4'd0:    pow10 = 32'd1;
         4'd1:    pow10 = 32'd10;
         4'd2:    pow10 = 32'd100;
         4'd3:    pow10 = 32'd1000;
         4'd4:    pow10 = 32'd10000;
         4'd5:    pow10 = 32'd100000;
         4'd6:    pow10 = 32'd1000000;
         4'd7:    pow10 = 32'd10000000;
         4'd8:    pow10 = 32'd100000000;
         4'd9:    pow10 = 32'd1000000000;
         default: pow10 = 32'd1;
      endcase
   endfunction

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      pow_idx_d   = pow_idx_q;
      digit_d     = digit_q;
      started_d   = started_q;
      tx_string_d = tx_string_q;
      tx_length_d = tx_length_q;
      tx_req_d    = 1'b0;
      fmt_done_d  = 1'b0;
      pow_val     = pow10(pow_idx_q);

      case (state_q)
         ST_IDLE: begin
            if (fmt_req) begin
               rem_d              = value_in;
               tx_string_d        = '0;
               tx_string_d[7:0]   = tag_in;
               tx_string_d[15:8]  = 8'h3D;
               tx_length_d        = 8'd2;
               pow_idx_d          = 4'd9;
               digit_d            = '0;
               started_d          = 1'b0;
               state_d            = ST_CONV;
            end
         end
         ST_CONV: begin
            // Repeated subtraction: one subtraction per cycle, then one
            // cycle per decimal place to emit the digit and move down.
            if (rem_q >= pow_val) begin
               rem_d   = rem_q - pow_val;
               digit_d = digit_q + 4'd1;
            end else begin
               // Suppress leading zeros, but always emit the units digit
               if ((digit_q != '0) || started_q || (pow_idx_q == '0)) begin
                  tx_string_d[{tx_length_q[6:0], 3'b000} +: 8] = 8'h30 + 8'(digit_q);
                  tx_length_d = tx_length_q + 8'd1;
                  started_d   = 1'b1;
               end
               digit_d = '0;
               if (pow_idx_q == '0) begin
                  state_d = ST_SEND;
               end else begin
                  pow_idx_d = pow_idx_q - 4'd1;
               end
            end
         end
         ST_SEND: begin
            if (!tx_busy) begin
               tx_req_d = 1'b1;
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (tx_done) begin
               fmt_done_d = 1'b1;
               state_d    = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      fmt_busy_d = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= ST_IDLE;
         rem_q       <= '0;
         pow_idx_q   <= '0;
         digit_q     <= '0;
         started_q   <= 1'b0;
         tx_string_q <= '0;
         tx_length_q <= '0;
         tx_req_q    <= 1'b0;
         fmt_busy_q  <= 1'b0;
         fmt_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         pow_idx_q   <= pow_idx_d;
         digit_q     <= digit_d;
         started_q   <= started_d;
         tx_string_q <= tx_string_d;
         tx_length_q <= tx_length_d;
         tx_req_q    <= tx_req_d;
         fmt_busy_q  <= fmt_busy_d;
         fmt_done_q  <= fmt_done_d;
      end
   end

   assign tx_string = tx_string_q;
   assign tx_length = tx_length_q;
   assign tx_req    = tx_req_q;
   assign fmt_busy  = fmt_busy_q;
   assign fmt_done  = fmt_done_q;

endmodule

// File: tb/tb_uart_value_formatter.sv
// Bench for uart_value_formatter: stimulus pushes expected messages into a
// scoreboard queue; a monitor pops and checks on every tx_req and models the
// string transmitter's tx_done response.
module tb_uart_value_formatter;

   typedef struct {
      logic [1023:0] s;
      logic [7:0]    len;
      int            cyc;
   } exp_t;

   logic          sys_clk;
   logic          sys_rst_n;
   logic [31:0]   value_in;
   logic [7:0]    tag_in;
   logic          fmt_req;
   logic          fmt_busy;
   logic          fmt_done;
   logic [1023:0] tx_string;
   logic [7:0]    tx_length;
   logic          tx_req;
   logic          tx_busy;
   logic          tx_done = 1'b0;

   exp_t q[$];
   int   cyc      = 0;
   int   n_chk    = 0;
   int   n_fail   = 0;
   int   n_txreq  = 0;
   int   cd       = 0;
   bit   exp_done = 1'b0;

   uart_value_formatter dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .value_in  (value_in),
      .tag_in    (tag_in),
      .fmt_req   (fmt_req),
      .fmt_busy  (fmt_busy),
      .fmt_done  (fmt_done),
      .tx_string (tx_string),
      .tx_length (tx_length),
      .tx_req    (tx_req),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [1023:0] mk(input string st);
      logic [1023:0] r;
      r = '0;
      for (int i = 0; i < st.len(); i++) r[8*i +: 8] = st[i];
      return r;
   endfunction

   task automatic chk_w(input string name, input logic [1023:0] act, input logic [1023:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got low bytes %0h required %0h (full vector differs)",
                  name, act[127:0], exp[127:0]);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // Monitor + transmitter model
   initial begin
      forever begin
         @(negedge sys_clk);
         if (exp_done) begin
            chk_i("fmt_done_after_tx_done", int'(fmt_done), 1);
            exp_done = 1'b0;
            tx_done  = 1'b0;
         end else if (fmt_done === 1'b1) begin
            chk_i("unexpected_fmt_done", int'(fmt_done), 0);
         end
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               tx_done  = 1'b1;
               exp_done = 1'b1;
            end
         end
         if (tx_req === 1'b1) begin
            exp_t e;
            n_txreq++;
            if (q.size() == 0) begin
               chk_i("unexpected_tx_req", int'(tx_req), 0);
            end else begin
               e = q.pop_front();
               chk_w("tx_string", tx_string, e.s);
               chk_i("tx_length", int'(tx_length), int'(e.len));
               chk_i("tx_req_cycle", cyc, e.cyc);
               cd = 3;
            end
         end
      end
   end

   // One message: lat is the hand-computed 11+S, hold the tx_busy cycles in SEND
   task automatic run_msg(input logic [31:0] v, input string st, input int lat,
                          input int hold, input bit poke);
      exp_t e;
      int   acc;
      int   n;
      @(negedge sys_clk);
      if (hold > 0) tx_busy = 1'b1;
      value_in = v;
      tag_in   = st[0];
      fmt_req  = 1'b1;
      acc      = cyc + 1;
      e.s   = mk(st);
      e.len = 8'(st.len());
      e.cyc = acc + lat + hold;
      q.push_back(e);
      @(negedge sys_clk);
      fmt_req = 1'b0;
      chk_i("fmt_busy_after_accept", int'(fmt_busy), 1);
      if (poke) begin
         repeat (4) @(negedge sys_clk);
         fmt_req = 1'b1;
         @(negedge sys_clk);
         fmt_req = 1'b0;
      end
      if (hold > 0) begin
         while (cyc < acc + lat + hold - 1) @(negedge sys_clk);
         tx_busy = 1'b0;
      end
      n = 0;
      while (fmt_done !== 1'b1 && n < 400) begin
         @(negedge sys_clk);
         n++;
      end
      chk_i("fmt_done_seen", int'(fmt_done), 1);
      @(negedge sys_clk);
      chk_i("fmt_busy_back_idle", int'(fmt_busy), 0);
   endtask

   initial begin
      sys_rst_n = 1'b0;
      value_in  = '0;
      tag_in    = '0;
      fmt_req   = 1'b0;
      tx_busy   = 1'b0;
      repeat (3) @(negedge sys_clk);
      chk_i("rst_fmt_busy", int'(fmt_busy), 0);
      chk_i("rst_fmt_done", int'(fmt_done), 0);
      chk_i("rst_tx_req", int'(tx_req), 0);
      chk_i("rst_tx_length", int'(tx_length), 0);
      chk_w("rst_tx_string", tx_string, '0);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);

      run_msg(32'd0,          "F=0",          11, 0,  1'b0);
      run_msg(32'd12345,      "F=12345",      26, 0,  1'b0);
      run_msg(32'd4294967295, "A=4294967295", 68, 0,  1'b0);
      run_msg(32'd1000000000, "F=1000000000", 12, 0,  1'b0);
      run_msg(32'd9,          "F=9",          20, 0,  1'b0);
      run_msg(32'd12345,      "B=12345",      26, 50, 1'b0);
      run_msg(32'd9,          "F=9",          20, 0,  1'b1);

      // Reset in the middle of a conversion aborts the message
      @(negedge sys_clk);
      value_in = 32'd12345;
      tag_in   = 8'h46;
      fmt_req  = 1'b1;
      @(negedge sys_clk);
      fmt_req  = 1'b0;
      repeat (5) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      #1;
      chk_i("midrst_fmt_busy", int'(fmt_busy), 0);
      chk_i("midrst_fmt_done", int'(fmt_done), 0);
      chk_i("midrst_tx_req", int'(tx_req), 0);
      chk_i("midrst_tx_length", int'(tx_length), 0);
      chk_w("midrst_tx_string", tx_string, '0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (80) @(negedge sys_clk);
      chk_i("postrst_fmt_busy", int'(fmt_busy), 0);

      chk_i("total_tx_req_pulses", n_txreq, 7);
      chk_i("scoreboard_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_value_formatter.md
UART_VALUE_FORMATTER -- requirements
Module: uart_value_formatter

Interface
REQ-001 SHALL have port sys_clk, input, 1, system clock; all logic on its rising edge.
REQ-002 SHALL have port sys_rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port value_in, input, 32, unsigned value to format; sampled on accept.
REQ-004 SHALL have port tag_in, input, 8, ASCII label character; sampled on accept.
REQ-005 SHALL have port fmt_req, input, 1, request to format and send one message.
REQ-006 SHALL have port fmt_busy, output, 1, high whenever the FSM is not IDLE.
REQ-007 SHALL have port fmt_done, output, 1, one-cycle pulse when the message has been fully sent.
REQ-008 SHALL have port tx_string, output, 1024, message bytes; byte k (k=0 sent first) at bits [8k+7:8k].
REQ-009 SHALL have port tx_length, output, 8, number of valid message bytes.
REQ-010 SHALL have port tx_req, output, 1, one-cycle send request to the string transmitter.
REQ-011 SHALL have port tx_busy, input, 1, string transmitter busy.
REQ-012 SHALL have port tx_done, input, 1, string transmitter one-cycle completion pulse.

Function
REQ-013 SHALL build the message tag_in, "=", then the decimal digits of value_in, MSD first, with no leading zeros; value 0 SHALL give the single digit "0".
REQ-014 SHALL set tx_length to 2 + digit count, with a range of 3..12.
REQ-015 SHALL use the states IDLE, CONV, SEND, WAIT, DONE, all registered.
REQ-016 IDLE, fmt_req=1: SHALL latch value_in into rem, clear tx_string, write byte0=tag_in and byte1=0x3D, set tx_length=2, set pow_idx=9, digit=0, started=0, and go to CONV.
REQ-017 CONV: if rem >= 10^pow_idx, SHALL do rem -= 10^pow_idx and digit += 1, one subtraction per cycle.
REQ-018 CONV: otherwise, if digit!=0, started=1, or pow_idx=0, SHALL write byte[tx_length] = 0x30+digit, increment tx_length, and set started=1.
REQ-019 CONV, in that same cycle: SHALL clear digit, and SHALL go to SEND if pow_idx=0, else decrement pow_idx.
REQ-020 CONV SHALL last exactly 10 + S cycles, where S is the sum of the decimal digits of value_in.
REQ-021 The 10^n constants SHALL be 32-bit; comparison and subtraction SHALL be 32-bit unsigned with no overflow for any input.
REQ-022 SEND: if tx_busy=0, SHALL register tx_req=1 for exactly one cycle and go to WAIT; if tx_busy=1, SHALL hold in SEND with tx_req=0.
REQ-023 tx_string and tx_length SHALL be stable from the SEND entry until the FSM returns to IDLE.
REQ-024 WAIT: on tx_done=1, SHALL go to DONE; otherwise stay in WAIT; tx_req SHALL stay 0.
REQ-025 DONE: SHALL pulse fmt_done=1 for one cycle and return to IDLE.
REQ-026 fmt_req SHALL be ignored in every state other than IDLE; there is no queuing.
REQ-027 fmt_req held high SHALL start a new message from the IDLE cycle following DONE.
REQ-028 tx_req SHALL be high in the (11+S)th cycle after the accepting edge when tx_busy=0.
REQ-029 A tx_done pulse outside WAIT SHALL be ignored.

Reset
REQ-030 On sys_rst_n=0 (asynchronous), the FSM SHALL go to IDLE.
REQ-031 On reset, tx_string, tx_length, tx_req, fmt_busy, fmt_done, rem, digit, pow_idx and started SHALL all be 0.
REQ-032 Reset mid-CONV, SEND or WAIT SHALL abort the message; after release, no tx_req or fmt_done SHALL occur until a new fmt_req.

Verification
REQ-033 value_in=0, tag="F", tx_busy=0 -> bytes "F=0", tx_length=3, tx_req 11 cycles after accept.
REQ-034 value_in=12345, tag="F" -> "F=12345", tx_length=7, tx_req 26 cycles after accept; tx_done -> fmt_done next cycle.
REQ-035 value_in=4294967295, tag="A" -> "A=4294967295", tx_length=12, bytes 12..127 = 0.
REQ-036 Message boundaries: value_in=1000000000 -> "F=1000000000", tx_length=12; value_in=9 -> "F=9", tx_length=3.
REQ-037 tx_busy held high 50 cycles at SEND entry -> no tx_req until tx_busy falls, then exactly one tx_req pulse.
REQ-038 Reset and request edges:
- fmt_req pulsed during CONV -> ignored, and exactly one message is sent.
- sys_rst_n low mid-CONV -> all outputs 0, no later tx_req.
